i2s_mic_rx4: RTL



---
 rtl/i2s_mic_rx4.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/i2s_mic_rx4.sv
// -----------------------------------------------------------------------------
// i2s_mic_rx4 - four-microphone I2S capture front end.
//
// Oversamples the PLL bit clock (i2s_sck) in the clk domain, generates the
// shared word select (i2s_ws), and deserialises the left-slot sample of four
// mono microphones. Each completed 4-channel frame is offered on a
// valid/ready output register.
//
// Ports:
//   clk, reset        system clock; synchronous active-high reset
//   enable            capture enable; 0 holds the bit counter and WS at 0
//   i2s_sck           bit clock, asynchronous to clk, at most clk/8
//   i2s_ws            word select to the mics (0 = left slot)
//   i2s_sd1..i2s_sd4  mic serial data
//   sample_ch0..3     captured samples (ch0 = sd1 ... ch3 = sd4)
//   sample_valid      frame available
//   sample_ready      consumer accepts frame
//   overflow          sticky flag: a completed frame was dropped
//   clear_overflow    clears overflow (a simultaneous drop wins)
//   frame_count       frames loaded into the output register (wraps)
//
// Handshake: a frame transfers on any clk edge where sample_valid and
// sample_ready are both 1. sample_ch* are stable while sample_valid is 1 and
// the frame has not been accepted. A new frame may load on the same edge as a
// transfer, in which case sample_valid stays 1.
// -----------------------------------------------------------------------------
module i2s_mic_rx4 #(
    parameter int SLOT_BITS   = 32,
    parameter int SAMPLE_BITS = 24,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   i2s_sck,
    output logic                   i2s_ws,
    input  logic                   i2s_sd1,
    input  logic                   i2s_sd2,
    input  logic                   i2s_sd3,
    input  logic                   i2s_sd4,
    output logic [SAMPLE_BITS-1:0] sample_ch0,
    output logic [SAMPLE_BITS-1:0] sample_ch1,
    output logic [SAMPLE_BITS-1:0] sample_ch2,
    output logic [SAMPLE_BITS-1:0] sample_ch3,
    output logic                   sample_valid,
    input  logic                   sample_ready,
    output logic                   overflow,
    input  logic                   clear_overflow,
    output logic [CNT_W-1:0]       frame_count
);

    localparam int CW = $clog2(2 * SLOT_BITS);
    localparam logic [CW-1:0] LAST_CNT   = CW'(2 * SLOT_BITS - 1);
    localparam logic [CW-1:0] SLOT_START = CW'(SLOT_BITS);
    localparam logic [CW-1:0] SMP_LAST   = CW'(SAMPLE_BITS);

    // Synchronisers: sck_q[0]/[1] are the two sync stages, sck_q[2] is the
    // edge-detect delay. Data only needs the two sync stages because it is
    // sampled on the sck rise, which has the same pipeline depth.
    logic [2:0] sck_q;
    logic [3:0] sd_s1_q, sd_s2_q;
    logic [3:0] sd_in;

    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          ws_q, ws_d;
    logic          done_q, done_d;
    logic [3:0][SAMPLE_BITS-1:0] shift_q, shift_d;
    logic [3:0][SAMPLE_BITS-1:0] hold_q, hold_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic rise, fall, in_window, load, drop;

    assign sd_in = {i2s_sd4, i2s_sd3, i2s_sd2, i2s_sd1};
    assign rise  = sck_q[1] & ~sck_q[2];
    assign fall  = ~sck_q[1] & sck_q[2];

    // One-bit I2S delay: offset 0 of the left slot is skipped, the sample
    // occupies offsets 1..SAMPLE_BITS.
    assign in_window = (bit_cnt_q != '0) && (bit_cnt_q <= SMP_LAST);

    assign load = done_q & (~valid_q | sample_ready);
    assign drop = done_q & ~load;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        ws_d      = ws_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        valid_d   = valid_q;
        hold_d    = hold_q;
        ovf_d     = ovf_q;
        count_d   = count_q;

        if (!enable) begin
            bit_cnt_d = '0;
            ws_d      = 1'b0;
            shift_d   = '0;
        end else begin
            if (fall) begin
                bit_cnt_d = (bit_cnt_q == LAST_CNT) ? '0 : bit_cnt_q + 1'b1;
            end
            // bit_cnt only moves on a fall, so this lags it by one cycle.
            ws_d = (bit_cnt_q >= SLOT_START);
            if (rise && in_window) begin
                for (int i = 0; i < 4; i++) begin
                    shift_d[i] = {shift_q[i][SAMPLE_BITS-2:0], sd_s2_q[i]};
                end
                done_d = (bit_cnt_q == SMP_LAST);
            end
        end

        // Output register: the transfer clear comes first so a same-edge
        // load overrides it.
        if (valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            hold_d  = shift_q;
            count_d = count_q + 1'b1;
        end

        if (clear_overflow) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_q     <= '0;
            sd_s1_q   <= '0;
            sd_s2_q   <= '0;
            bit_cnt_q <= '0;
            ws_q      <= 1'b0;
            done_q    <= 1'b0;
            shift_q   <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            sck_q     <= {sck_q[1:0], i2s_sck};
            sd_s1_q   <= sd_in;
            sd_s2_q   <= sd_s1_q;
            bit_cnt_q <= bit_cnt_d;
            ws_q      <= ws_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            count_q   <= count_d;
        end
    end

    assign i2s_ws       = ws_q;
    assign sample_ch0   = hold_q[0];
    assign sample_ch1   = hold_q[1];
    assign sample_ch2   = hold_q[2];
    assign sample_ch3   = hold_q[3];
    assign sample_valid = valid_q;
    assign overflow     = ovf_q;
    assign frame_count  = count_q;

endmodule
